// File: rtl/flags_pkg.sv
// flags_pkg: flag bit indices, flag type, opcode constants
// and the logical-op carry-select helper.
package flags_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [3:0] flag_t;

  localparam logic [4:0] OP_AND = 5'd0;
  localparam logic [4:0] OP_EOR = 5'd1;
  localparam logic [4:0] OP_SUB = 5'd2;
  localparam logic [4:0] OP_RSB = 5'd3;
  localparam logic [4:0] OP_ADD = 5'd4;
  localparam logic [4:0] OP_ADC = 5'd5;
  localparam logic [4:0] OP_SBC = 5'd6;
  localparam logic [4:0] OP_RSC = 5'd7;
  localparam logic [4:0] OP_TST = 5'd8;
  localparam logic [4:0] OP_TEQ = 5'd9;
  localparam logic [4:0] OP_CMP = 5'd10;
  localparam logic [4:0] OP_CMN = 5'd11;
  localparam logic [4:0] OP_ORR = 5'd12;
  localparam logic [4:0] OP_MOV = 5'd13;
  localparam logic [4:0] OP_BIC = 5'd14;
  localparam logic [4:0] OP_MVN = 5'd15;

  // Logical ops take C from the shifter, arithmetic ops from the ALU.
  function automatic logic carry_sel(
    input logic [4:0] op,
    input logic       sh_c,
    input logic       alu_c
  );
    logic c;
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: c = sh_c;
      default: c = alu_c;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/flags_lifo.sv
// flags_lifo: per-context DEPTH x 4 saved-flags stack.
// push/pop arrive pre-qualified (never both, never on full/empty).
module flags_lifo
  import flags_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  flag_t            wr_data,
  output flag_t            rd_data,
  output logic [PTR_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  flag_t            mem [DEPTH];
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] top;

  assign top     = ptr - PTR_W'(1);
  assign rd_data = mem[top[AW-1:0]];
  assign depth   = ptr;
  assign full    = (ptr == PTR_W'(DEPTH));
  assign empty   = (ptr == '0);

  // Stack pointer: cleared by reset, moved by push/pop.
  always_ff @(posedge clk) begin
    if (rst) ptr <= '0;
    else if (push) ptr <= ptr + PTR_W'(1);
    else if (pop) ptr <= top;
  end

  // Entry storage; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) mem[ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/flags_bank.sv
// flags_bank: NCTX live NZCV sets, each with a saved-flags LIFO.
// Build option FLAGS_BYPASS_EN forwards next-edge flags onto Flags.
module flags_bank
  import flags_pkg::*;
#(
  parameter  int NCTX  = 2,
  parameter  int DEPTH = 4,
  localparam int CTX_W = (NCTX > 1) ? $clog2(NCTX) : 1,
  localparam int PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic [CTX_W-1:0] CtxSel,
  input  logic [3:0]       FlagWrite,
  input  logic [3:0]       ALUFlags,
  input  logic             ShifterCarry,
  input  logic [4:0]       Op,
  input  logic             Push,
  input  logic             Pop,
  input  logic             ErrClr,
  output logic [3:0]       Flags,
  output logic [PTR_W-1:0] StackDepth,
  output logic             Overflow,
  output logic             Underflow,
  output logic             ProtoErr
);

  flag_t            live   [NCTX];
  flag_t            top_a  [NCTX];
  logic [PTR_W-1:0] dep_a  [NCTX];
  logic             full_a [NCTX];
  logic             empt_a [NCTX];
  logic [NCTX-1:0]  hit;

  logic             in_range;
  flag_t            cur_live;
  flag_t            cur_top;
  logic [PTR_W-1:0] cur_dep;
  logic             cur_full;
  logic             cur_empty;
  flag_t            merged;
  flag_t            next_live;
  flag_t            flags_src;

  assign in_range = (int'(CtxSel) < NCTX);

  genvar g;
  generate
    for (g = 0; g < NCTX; g++) begin : g_ctx
      logic push_en;
      logic pop_en;
      assign hit[g]  = in_range && (CtxSel == CTX_W'(g));
      assign push_en = hit[g] & Push & ~Pop & ~full_a[g];
      assign pop_en  = hit[g] & Pop & ~Push & ~empt_a[g];
      flags_lifo #(.DEPTH(DEPTH)) u_lifo (
        .clk     (CLK),
        .rst     (Reset),
        .push    (push_en),
        .pop     (pop_en),
        .wr_data (live[g]),
        .rd_data (top_a[g]),
        .depth   (dep_a[g]),
        .full    (full_a[g]),
        .empty   (empt_a[g])
      );
    end
  endgenerate

  // Select the addressed context's live flags and stack status.
  always_comb begin
    cur_live  = '0;
    cur_top   = '0;
    cur_dep   = '0;
    cur_full  = 1'b0;
    cur_empty = 1'b1;
    for (int c = 0; c < NCTX; c++) begin
      if (hit[c]) begin
        cur_live  = live[c];
        cur_top   = top_a[c];
        cur_dep   = dep_a[c];
        cur_full  = full_a[c];
        cur_empty = empt_a[c];
      end
    end
  end

  // Next live value: restore on pop, else merged flag write.
  always_comb begin
    merged         = cur_live;
    merged[FLAG_N] = FlagWrite[FLAG_N] ? ALUFlags[FLAG_N]
                                       : cur_live[FLAG_N];
    merged[FLAG_Z] = FlagWrite[FLAG_Z] ? ALUFlags[FLAG_Z]
                                       : cur_live[FLAG_Z];
    merged[FLAG_V] = FlagWrite[FLAG_V] ? ALUFlags[FLAG_V]
                                       : cur_live[FLAG_V];
    merged[FLAG_C] = FlagWrite[FLAG_C]
                   ? carry_sel(Op, ShifterCarry, ALUFlags[FLAG_C])
                   : cur_live[FLAG_C];
    next_live = cur_live;
    if (Push && Pop) next_live = cur_live;
    else if (Pop) next_live = cur_empty ? cur_live : cur_top;
    else next_live = merged;
  end

  // Live flag registers; only the addressed context moves.
  always_ff @(posedge CLK) begin
    for (int c = 0; c < NCTX; c++) begin
      if (Reset) live[c] <= '0;
      else if (hit[c]) live[c] <= next_live;
    end
  end

  // Sticky errors; a new event outranks a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
      ProtoErr  <= 1'b0;
    end else begin
      Overflow  <= (in_range & Push & ~Pop & cur_full)
                 | (Overflow & ~ErrClr);
      Underflow <= (in_range & Pop & ~Push & cur_empty)
                 | (Underflow & ~ErrClr);
      ProtoErr  <= (in_range & Push & Pop)
                 | (ProtoErr & ~ErrClr);
    end
  end

`ifdef FLAGS_BYPASS_EN
  assign flags_src = next_live;
`else
  assign flags_src = cur_live;
`endif

  assign Flags      = in_range ? flags_src : 4'b0000;
  assign StackDepth = in_range ? cur_dep : '0;

endmodule

// File: tb/tb_flags_bank.sv
// tb_flags_bank: directed checks of flags_bank (NCTX=2, DEPTH=4),
// including the FLAGS_BYPASS_EN visibility difference.
module tb_flags_bank;
  import flags_pkg::*;

  logic       CLK;
  logic       Reset;
  logic [0:0] CtxSel;
  logic [3:0] FlagWrite;
  logic [3:0] ALUFlags;
  logic       ShifterCarry;
  logic [4:0] Op;
  logic       Push;
  logic       Pop;
  logic       ErrClr;
  logic [3:0] Flags;
  logic [2:0] StackDepth;
  logic       Overflow;
  logic       Underflow;
  logic       ProtoErr;

  int checks = 0;
  int failures = 0;

  flags_bank #(.NCTX(2), .DEPTH(4)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .CtxSel       (CtxSel),
    .FlagWrite    (FlagWrite),
    .ALUFlags     (ALUFlags),
    .ShifterCarry (ShifterCarry),
    .Op           (Op),
    .Push         (Push),
    .Pop          (Pop),
    .ErrClr       (ErrClr),
    .Flags        (Flags),
    .StackDepth   (StackDepth),
    .Overflow     (Overflow),
    .Underflow    (Underflow),
    .ProtoErr     (ProtoErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // Clock once, then return strobes to idle.
  task automatic cyc();
    @(posedge CLK);
    #1;
    Reset     = 1'b0;
    FlagWrite = 4'b0000;
    Push      = 1'b0;
    Pop       = 1'b0;
    ErrClr    = 1'b0;
  endtask

  task automatic wr(input logic [3:0] fw, input logic [3:0] alu,
                    input logic [4:0] op, input logic sc);
    FlagWrite    = fw;
    ALUFlags     = alu;
    Op           = op;
    ShifterCarry = sc;
  endtask

  initial begin
    Reset = 1'b1; CtxSel = '0; FlagWrite = '0; ALUFlags = '0;
    ShifterCarry = 1'b0; Op = OP_ADD; Push = 1'b0; Pop = 1'b0;
    ErrClr = 1'b0;
    #2;
    cyc();
    chk("rst_flags", {4'h0, Flags}, 8'h00);
    chk("rst_depth", {5'h0, StackDepth}, 8'h00);
    chk("rst_err", {5'h0, Overflow, Underflow, ProtoErr}, 8'h00);

    // Arithmetic op: C from ALU.
    wr(4'b1111, 4'b1010, OP_ADD, 1'b0); cyc();
    chk("add_flags", {4'h0, Flags}, 8'h0a);
    // Logical op: C from shifter.
    wr(4'b1111, 4'b1010, OP_MOV, 1'b0); cyc();
    chk("mov_flags", {4'h0, Flags}, 8'h08);

    // Push with simultaneous write saves the old value.
    wr(4'b1111, 4'b1100, OP_ADD, 1'b0); cyc();
    chk("set_1100", {4'h0, Flags}, 8'h0c);
    wr(4'b1111, 4'b0011, OP_ADD, 1'b0); Push = 1'b1; cyc();
    chk("push_flags", {4'h0, Flags}, 8'h03);
    chk("push_depth", {5'h0, StackDepth}, 8'h01);
    wr(4'b1111, 4'b0101, OP_ADD, 1'b0); Pop = 1'b1; cyc();
    chk("pop_flags", {4'h0, Flags}, 8'h0c);
    chk("pop_depth", {5'h0, StackDepth}, 8'h00);

    // Ctx1: five pushes, each also writing a new live value.
    CtxSel = 1'b1; #1;
    chk("ctx1_init", {4'h0, Flags}, 8'h00);
    wr(4'b1111, 4'b0001, OP_ADD, 1'b0); Push = 1'b1; cyc();
    wr(4'b1111, 4'b0010, OP_ADD, 1'b0); Push = 1'b1; cyc();
    wr(4'b1111, 4'b0100, OP_ADD, 1'b0); Push = 1'b1; cyc();
    wr(4'b1111, 4'b1000, OP_ADD, 1'b0); Push = 1'b1; cyc();
    chk("ovf_pre", {7'h0, Overflow}, 8'h00);
    wr(4'b1111, 4'b1111, OP_ADD, 1'b0); Push = 1'b1; cyc();
    chk("full_depth", {5'h0, StackDepth}, 8'h04);
    chk("ovf_set", {7'h0, Overflow}, 8'h01);
    chk("full_live", {4'h0, Flags}, 8'h0f);
    CtxSel = 1'b0; #1;
    chk("ctx0_depth", {5'h0, StackDepth}, 8'h00);
    chk("ctx0_flags", {4'h0, Flags}, 8'h0c);
    CtxSel = 1'b1;

    // Pops restore in LIFO order; FlagWrite ignored.
    wr(4'b1111, 4'b1111, OP_ADD, 1'b0); Pop = 1'b1; cyc();
    chk("pop1", {1'b0, StackDepth, Flags}, 8'h34);
    Pop = 1'b1; cyc();
    chk("pop2", {1'b0, StackDepth, Flags}, 8'h22);
    Pop = 1'b1; cyc();
    chk("pop3", {1'b0, StackDepth, Flags}, 8'h11);
    Pop = 1'b1; cyc();
    chk("pop4", {1'b0, StackDepth, Flags}, 8'h00);
    chk("unf_pre", {7'h0, Underflow}, 8'h00);
    wr(4'b1111, 4'b1111, OP_ADD, 1'b0); Pop = 1'b1; cyc();
    chk("pop5", {1'b0, StackDepth, Flags}, 8'h00);
    chk("unf_set", {7'h0, Underflow}, 8'h01);
    ErrClr = 1'b1; cyc();
    chk("errclr", {6'h0, Overflow, Underflow}, 8'h00);

    // Push+Pop together on ctx0.
    CtxSel = 1'b0;
    wr(4'b1111, 4'b0101, OP_ADD, 1'b0); Push = 1'b1; Pop = 1'b1;
    cyc();
    chk("pp_state", {1'b0, StackDepth, Flags}, 8'h0c);
    chk("pp_err", {7'h0, ProtoErr}, 8'h01);
    Push = 1'b1; Pop = 1'b1; ErrClr = 1'b1; cyc();
    chk("err_wins", {7'h0, ProtoErr}, 8'h01);
    ErrClr = 1'b1; cyc();
    chk("proto_clr", {7'h0, ProtoErr}, 8'h00);

    // Partial write latency.
    wr(4'b1111, 4'b0000, OP_ADD, 1'b0); cyc();
    chk("zero", {4'h0, Flags}, 8'h00);
    wr(4'b0100, 4'b0100, OP_ADD, 1'b0); #1;
`ifdef FLAGS_BYPASS_EN
    chk("z_same", {4'h0, Flags}, 8'h04);
`else
    chk("z_same", {4'h0, Flags}, 8'h00);
`endif
    cyc();
    chk("z_next", {4'h0, Flags}, 8'h04);
    wr(4'b0010, 4'b0000, OP_TST, 1'b1); cyc();
    chk("tst_c", {4'h0, Flags}, 8'h06);

    // Reset mid-operation after a push on ctx1.
    CtxSel = 1'b1;
    wr(4'b1111, 4'b1001, OP_ADD, 1'b0); Push = 1'b1; cyc();
    chk("mid_depth", {5'h0, StackDepth}, 8'h01);
    Reset = 1'b1; cyc();
    chk("mid_rst", {1'b0, StackDepth, Flags}, 8'h00);
    chk("mid_err", {5'h0, Overflow, Underflow, ProtoErr}, 8'h00);
    CtxSel = 1'b0; #1;
    chk("mid_ctx0", {1'b0, StackDepth, Flags}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
